// File: rtl/pes_water_pkg.sv
// Shared definitions for the water zone scheduler: FSM state encoding,
// default timing constants and a zone-index width helper.
package pes_water_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_VALVE_OPEN = 2'd1,
        S_PUMP_ON    = 2'd2,
        S_PUMP_OFF   = 2'd3
    } state_t;

    localparam int DEF_NZ            = 4;
    localparam int DEF_SETTLE_CYC    = 4;
    localparam int DEF_MIN_WATER_CYC = 8;
    localparam int DEF_MAX_WATER_CYC = 32;
    localparam int DEF_CNT_W         = 8;

    // Width of a zone index; a single-zone build still gets one bit.
    function automatic int zone_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pes_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting zone
// searching upward from ptr_i+1 with wrap. The pointer itself is owned
// by the parent.
module pes_rr_arbiter #(
    parameter int NZ = 4,
    parameter int ZW = 2
) (
    input  logic [NZ-1:0] req_i,
    input  logic [ZW-1:0] ptr_i,
    output logic [ZW-1:0] grant_o,
    output logic          valid_o
);

    logic [ZW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = NZ; k >= 1; k--) begin
            idx = ZW'((int'(ptr_i) + k) % NZ);
            if (req_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/pes_water_zone_scheduler.sv
// Shares one pump between NZ zones: grants a dry zone round-robin, opens
// its valve, settles, pumps for a bounded time, settles again, closes.
// New services are inhibited in daylight; a service is never preempted.
// Optional feature macro: PES_WATER_FAULT_LOCKOUT_EN (timeouts latch a
// sticky per-zone fault and exclude that zone from arbitration).
module pes_water_zone_scheduler
    import pes_water_pkg::*;
#(
    parameter  int NZ            = DEF_NZ,
    parameter  int SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter  int MIN_WATER_CYC = DEF_MIN_WATER_CYC,
    parameter  int MAX_WATER_CYC = DEF_MAX_WATER_CYC,
    parameter  int CNT_W         = DEF_CNT_W,
    localparam int ZW            = zone_w(NZ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NZ-1:0] moisture_sensor,
    input  logic          light_sensor,
    output logic          water_pump,
    output logic [NZ-1:0] valve,
    output logic          busy,
    output logic [ZW-1:0] active_zone,
    output logic [NZ-1:0] fault
);

    // Terminal counts expressed as "last cnt value" so compares never overflow.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_WATER_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_WATER_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ZW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ZW-1:0]    zone_q, zone_d;
    logic [NZ-1:0]    valve_q, valve_d;
    logic             pump_q, pump_d;

    logic [NZ-1:0]    eligible;
    logic [ZW-1:0]    grant_idx;
    logic             grant_valid;
    logic             zone_dry;
    logic             pump_done;

    assign zone_dry  = moisture_sensor[zone_q];
    // Leave after the minimum once the zone is wet, or unconditionally at the maximum.
    assign pump_done = ((cnt_q >= MIN_LAST) && !zone_dry) || (cnt_q == MAX_LAST);

`ifdef PES_WATER_FAULT_LOCKOUT_EN
    logic [NZ-1:0] fault_q, fault_d;
    logic          timeout;

    assign timeout  = (state_q == S_PUMP_ON) && (cnt_q == MAX_LAST) && zone_dry;
    assign eligible = moisture_sensor & ~fault_q;
    assign fault    = fault_q;

    // Latch a timeout on the served zone; cleared only by reset.
    always_comb begin
        fault_d = fault_q;
        if (timeout) begin
            fault_d[zone_q] = 1'b1;
        end
    end

    // Sticky fault register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= '0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign eligible = moisture_sensor;
    assign fault    = '0;
`endif

    pes_rr_arbiter #(
        .NZ (NZ),
        .ZW (ZW)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_idx),
        .valid_o (grant_valid)
    );

    // Next-state logic: grant, settle, pump, settle, release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        zone_d   = zone_q;
        valve_d  = valve_q;
        pump_d   = pump_q;
        case (state_q)
            S_IDLE: begin
                if (!light_sensor && grant_valid) begin
                    state_d            = S_VALVE_OPEN;
                    valve_d            = '0;
                    valve_d[grant_idx] = 1'b1;
                    zone_d             = grant_idx;
                    cnt_d              = '0;
                end
            end
            S_VALVE_OPEN: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_PUMP_ON;
                    pump_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PUMP_ON: begin
                if (pump_done) begin
                    state_d = S_PUMP_OFF;
                    pump_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PUMP_OFF: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d  = S_IDLE;
                    valve_d  = '0;
                    rr_ptr_d = zone_q;
                    zone_d   = '0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valve_d = '0;
                pump_d  = 1'b0;
                zone_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears outputs without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= ZW'(NZ - 1);
            zone_q   <= '0;
            valve_q  <= '0;
            pump_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            zone_q   <= zone_d;
            valve_q  <= valve_d;
            pump_q   <= pump_d;
        end
    end

    assign water_pump  = pump_q;
    assign valve       = valve_q;
    assign active_zone = zone_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pes_water_zone_scheduler.sv
// Self-checking bench for pes_water_zone_scheduler (default parameters).
// Table of single services plus directed sequences for round-robin,
// daylight, reset and no-preemption behaviour.
module tb_pes_water_zone_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] moisture_sensor;
    logic       light_sensor;
    logic       water_pump;
    logic [3:0] valve;
    logic       busy;
    logic [1:0] active_zone;
    logic [3:0] fault;

    int checks = 0;
    int errors = 0;

    pes_water_zone_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .moisture_sensor (moisture_sensor),
        .light_sensor    (light_sensor),
        .water_pump      (water_pump),
        .valve           (valve),
        .busy            (busy),
        .active_zone     (active_zone),
        .fault           (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        moisture_sensor = '0;
        light_sensor    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Runs one service from IDLE and measures its phases in clock cycles.
    task automatic do_service(input logic [3:0] mois, input int drop_cyc, input logic light_pump,
                              output int zone, output int azone, output int t_valve,
                              output int t_settle, output int t_pump, output int t_tail);
        moisture_sensor = mois;
        light_sensor    = 1'b0;
        t_valve = 0;
        do begin
            tick();
            t_valve++;
        end while (valve == 4'b0 && t_valve < 100);
        zone = -1;
        for (int i = 0; i < 4; i++) if (valve[i]) zone = i;
        azone = int'(active_zone);
        t_settle = 0;
        while (!water_pump && t_settle < 100) begin
            tick();
            t_settle++;
        end
        light_sensor = light_pump;
        t_pump = 0;
        while (water_pump && t_pump < 100) begin
            t_pump++;
            if (t_pump == drop_cyc && zone >= 0) moisture_sensor[zone] = 1'b0;
            tick();
        end
        t_tail = 0;
        while (valve != 4'b0 && t_tail < 100) begin
            tick();
            t_tail++;
        end
    endtask

    // Invariants sampled on the inactive edge every cycle.
    logic [3:0] prev_valve;
    logic       prev_pump;
    always @(negedge clk) begin
        if (reset) begin
            prev_valve = '0;
            prev_pump  = 1'b0;
        end else begin
            check("valve_onehot", 32'($onehot0(valve)), 32'd1);
            check("pump_implies_valve", 32'(!water_pump || (valve != 4'b0)), 32'd1);
            if (water_pump && prev_pump) check("valve_stable_pumping", 32'(valve), 32'(prev_valve));
            prev_valve = valve;
            prev_pump  = water_pump;
        end
    end

    typedef struct {
        logic [3:0] mois;
        int         drop;
        int         exp_zone;
        int         exp_len;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int zone, azone, t_valve, t_settle, t_pump, t_tail, n;
        logic bad;

        // rr pointer starts at 3; each row's grant follows from the previous row.
        vecs[0] = '{4'b0010, 3,  1, 8};   // single zone, drop on 3rd pump cycle
        vecs[1] = '{4'b0001, 10, 0, 10};  // wrap past zone 3 to zone 0
        vecs[2] = '{4'b1001, 8,  3, 8};   // drop exactly at MIN
        vecs[3] = '{4'b0110, 20, 1, 20};  // ptr 3 -> first dry above is 1
        vecs[4] = '{4'b0100, 1,  2, 8};   // early drop does not shorten
        vecs[5] = '{4'b1000, 32, 3, 32};  // drop on the MAX cycle: not a timeout
        vecs[6] = '{4'b0001, 9,  0, 9};   // one past MIN

        reset = 1'b0;
        moisture_sensor = '0;
        light_sensor = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_pump", 32'(water_pump), 32'd0);
        check("rst_valve", 32'(valve), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_zone", 32'(active_zone), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven single services.
        for (int v = 0; v < 7; v++) begin
            do_service(vecs[v].mois, vecs[v].drop, 1'b0, zone, azone, t_valve, t_settle, t_pump, t_tail);
            check($sformatf("v%0d_zone", v), 32'(zone), 32'(vecs[v].exp_zone));
            check($sformatf("v%0d_active_zone", v), 32'(azone), 32'(vecs[v].exp_zone));
            check($sformatf("v%0d_valve_delay", v), 32'(t_valve), 32'd1);
            check($sformatf("v%0d_settle", v), 32'(t_settle), 32'd4);
            check($sformatf("v%0d_pump_len", v), 32'(t_pump), 32'(vecs[v].exp_len));
            check($sformatf("v%0d_tail", v), 32'(t_tail), 32'd4);
            check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_zone_end", v), 32'(active_zone), 32'd0);
        end
        moisture_sensor = '0;
        tick();
        check("table_fault", 32'(fault), 32'd0);

        // All zones held dry: 0,1,2,3 each time out at 32 cycles.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            do_service(4'hF, 0, 1'b0, zone, azone, t_valve, t_settle, t_pump, t_tail);
            check($sformatf("rr%0d_zone", s), 32'(zone), 32'(s));
            check($sformatf("rr%0d_gap", s), 32'(t_valve), 32'd1);
            check($sformatf("rr%0d_pump_len", s), 32'(t_pump), 32'd32);
        end
`ifdef PES_WATER_FAULT_LOCKOUT_EN
        check("rr_fault_all", 32'(fault), 32'hF);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valve != 4'b0 || busy) bad = 1'b1;
        end
        check("rr_locked_out", 32'(bad), 32'd0);
`else
        check("rr_fault_zero", 32'(fault), 32'd0);
        do_service(4'hF, 0, 1'b0, zone, azone, t_valve, t_settle, t_pump, t_tail);
        check("rr4_zone", 32'(zone), 32'd0);
        check("rr4_pump_len", 32'(t_pump), 32'd32);
`endif
        moisture_sensor = '0;

        // Daylight blocks new services but not one in progress.
        do_reset();
        light_sensor = 1'b1;
        moisture_sensor = 4'b0100;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valve != 4'b0 || busy) bad = 1'b1;
        end
        check("day_no_service", 32'(bad), 32'd0);
        do_service(4'b0100, 3, 1'b1, zone, azone, t_valve, t_settle, t_pump, t_tail);
        check("dusk_valve_delay", 32'(t_valve), 32'd1);
        check("dusk_zone", 32'(zone), 32'd2);
        check("day_mid_pump_len", 32'(t_pump), 32'd8);
        check("day_mid_tail", 32'(t_tail), 32'd4);
        moisture_sensor = 4'b0100;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valve != 4'b0 || busy) bad = 1'b1;
        end
        check("day_after_blocked", 32'(bad), 32'd0);
        light_sensor = 1'b0;
        moisture_sensor = '0;

        // Reset mid-pump clears outputs without a clock edge.
        do_reset();
        moisture_sensor = 4'b0001;
        n = 0;
        while (!water_pump && n < 100) begin
            tick();
            n++;
        end
        check("rst_mid_reached_pump", 32'(water_pump), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_pump", 32'(water_pump), 32'd0);
        check("rst_mid_valve", 32'(valve), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        tick();
        moisture_sensor = 4'b1010;
        reset = 1'b0;
        n = 0;
        while (valve == 4'b0 && n < 100) begin
            tick();
            n++;
        end
        check("post_rst_valve", 32'(valve), 32'b0010);
        check("post_rst_zone", 32'(active_zone), 32'd1);
        moisture_sensor = '0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("post_rst_done", 32'(busy), 32'd0);

        // No preemption: zone 2 waits for zone 0 to finish.
        do_reset();
        moisture_sensor = 4'b0001;
        n = 0;
        while (!water_pump && n < 100) begin
            tick();
            n++;
        end
        check("np_reached_pump", 32'(water_pump), 32'd1);
        moisture_sensor = 4'b0100;
        bad = 1'b0;
        n = 0;
        while (valve != 4'b0 && n < 100) begin
            if (valve != 4'b0001) bad = 1'b1;
            tick();
            n++;
        end
        check("np_valve_held", 32'(bad), 32'd0);
        check("np_hold_cycles", 32'(n), 32'd12);
        tick();
        check("np_next_valve", 32'(valve), 32'b0100);
        check("np_next_zone", 32'(active_zone), 32'd2);
        moisture_sensor = '0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("np_done", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pes_water_zone_scheduler.md
Name: pes_water_zone_scheduler

Overview:
- Shares one water pump between NZ plant zones, each with its own valve and moisture sensor.
- Picks a dry zone round-robin, opens its valve, runs the pump for a bounded time, then closes down safely.
- Sits between the per-zone sensors and the pump/valve drivers, and replaces direct sensor-to-pump wiring.
- Inhibits new watering cycles during daylight.

Parameters:
- NZ, 4, number of zones.
- SETTLE_CYC, 4, cycles the valve is open before the pump starts, and cycles it stays open after the pump stops.
- MIN_WATER_CYC, 8, minimum pump-on cycles per service.
- MAX_WATER_CYC, 32, maximum pump-on cycles per service (timeout).
- CNT_W, 8, counter width; must hold MAX_WATER_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- moisture_sensor  in  NZ  per-zone dry flag, 1 = zone needs water
- light_sensor  in  1  1 = daylight; blocks new services
- water_pump  out  1  pump enable, registered
- valve  out  NZ  one-hot valve enables, registered
- busy  out  1  high in any state except IDLE
- active_zone  out  clog2(NZ)  index of the zone being served; 0 when idle
- fault  out  NZ  sticky per-zone timeout flags

Behaviour:
- Reset is asynchronous and active-high. On reset, all outputs go to 0 immediately, with no clock edge needed.
  - Reset state: IDLE, cnt=0, rr_ptr=NZ-1 (so zone 0 wins first), fault cleared.
- States are IDLE, VALVE_OPEN, PUMP_ON, PUMP_OFF.
- IDLE:
  - A zone is eligible when moisture_sensor[i]=1, and also fault[i]=0 if lockout is compiled in.
  - If light_sensor=0 and at least one zone is eligible, grant zone z: the first eligible zone searching upward from rr_ptr+1, with wrap.
  - On the next edge: valve[z]=1, active_zone=z, cnt=0, go to VALVE_OPEN. Valve therefore rises 1 cycle after the request is sampled.
- VALVE_OPEN:
  - cnt increments each cycle.
  - At cnt==SETTLE_CYC-1, go to PUMP_ON with water_pump=1 and cnt=0.
  - The valve is open alone for exactly SETTLE_CYC cycles before the pump starts.
- PUMP_ON:
  - Pumped cycles so far = cnt+1.
  - Exit to PUMP_OFF when (cnt+1>=MIN_WATER_CYC and moisture_sensor[z]=0) or cnt+1==MAX_WATER_CYC.
  - The pump is therefore high for N cycles, with MIN_WATER_CYC <= N <= MAX_WATER_CYC.
  - If exit is by MAX while moisture_sensor[z]=1, the service is a timeout (see Optional Feature).
- PUMP_OFF:
  - water_pump=0 and the valve stays open for SETTLE_CYC cycles.
  - Then valve=0, rr_ptr=z, active_zone=0, go to IDLE.
- Invariants:
  - water_pump=1 implies exactly one valve bit is high.
  - The valve vector never changes while water_pump=1.
  - valve is always one-hot or zero.
- A service in progress is never preempted:
  - Requests from other zones during a service are ignored until IDLE.
  - light_sensor rising mid-service does not abort it.
  - The granted zone's moisture dropping before MIN does not shorten the pump time.
- IDLE with no eligible zone or light_sensor=1: hold, all outputs 0.
- Minimum gap between two services is 1 IDLE cycle.

Optional Feature:
- Macro: PES_WATER_FAULT_LOCKOUT_EN.
- Defined:
  - A timeout sets fault[z] sticky until reset.
  - Faulted zones are excluded from arbitration.
- Undefined:
  - fault is tied to 0.
  - A timed-out zone stays eligible and is re-served in normal round-robin order.

Decomposition:
- Package pes_water_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_VALVE_OPEN=2'd1, S_PUMP_ON=2'd2, S_PUMP_OFF=2'd3
  - default timing constants
- Sub-module pes_rr_arbiter:
  - Inputs: req[NZ], ptr. Outputs: grant index and valid.
  - Purely combinational. rr_ptr update stays in the parent.

Test Plan:
1. Single-zone service, parameters at defaults, dark: moisture[1]=1; it drops to 0 on the 3rd pump cycle.
   - valve[1] rises 1 cycle later; pump rises 4 cycles later.
   - Pump stays high for exactly 8 cycles; valve falls 4 cycles after the pump falls; busy returns to 0.
2. All four zones held dry:
   - Grant order is 0,1,2,3,0; each pump burst is 32 cycles.
   - With lockout defined: fault=4'b1111 after 4 services, then no further grants.
   - Without lockout: service 5 goes to zone 0.
3. Daylight handling:
   - light_sensor=1 with moisture=4'b0100: no valve activity for 50 cycles.
   - light_sensor falls: valve[2] rises on the next edge.
   - light_sensor rises during PUMP_ON: the service completes normally.
4. Reset mid-service:
   - Assert reset during PUMP_ON: water_pump, valve and busy go to 0 before the next clk edge.
   - After release with moisture=4'b1010: zone 1 is granted first.
5. No preemption:
   - Zone 2 asserts during zone 0's PUMP_ON: valve stays 4'b0001 until zone 0's PUMP_OFF ends.
   - Zone 2 is granted after 1 IDLE cycle.
   - The one-hot and pump⇒valve invariants are checked every cycle.
